// File: rtl/sfa_sched.sv
// rtl/sfa_sched.sv - round-robin time-multiplexed scale-factor adaptation scheduler (optional clr port: SFA_CLEAR_EN)
module sfa_sched #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NCH-1:0]       i_req,
    input  logic [12*NCH-1:0]    i_wi,
`ifdef SFA_CLEAR_EN
    input  logic [NCH-1:0]       i_clr,
`endif
    output logic [NCH-1:0]       o_ack,
    output logic                 o_out_valid,
    output logic [CHW-1:0]       o_out_ch,
    output logic [12:0]          o_out_y
);

    localparam logic [12:0] Y_MIN = 13'd544;
    localparam logic [12:0] Y_MAX = 13'd5120;

    // per-channel scale factors and arbiter pointer
    logic [12:0]    r_y [NCH];
    logic [CHW-1:0] r_rr_ptr;

    // stage-1 (granted request) registers
    logic           r_s1_v;
    logic [CHW-1:0] r_s1_ch;
    logic [11:0]    r_s1_wi;
    logic [12:0]    r_s1_y;

    // output registers
    logic [NCH-1:0] r_ack;
    logic           r_out_valid;
    logic [CHW-1:0] r_out_ch;
    logic [12:0]    r_out_y;

    logic [11:0]    w_wi_arr [NCH];
    logic [NCH-1:0] w_elig;
    logic           w_gnt_found;
    logic [CHW-1:0] w_gnt_ch;
    logic [11:0]    w_dif_hi;
    logic [12:0]    w_difsx;
    logic [12:0]    w_yut;
    logic [12:0]    w_yu;
    logic [NCH-1:0] w_clr;

`ifdef SFA_CLEAR_EN
    assign w_clr = i_clr;
`else
    assign w_clr = '0;
`endif

    // unpack per-channel WI and mark channels eligible (requesting and not already in flight)
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_wi_arr[c] = i_wi[12*c +: 12];
            w_elig[c]   = i_req[c] && !(r_s1_v && (r_s1_ch == CHW'(c)));
        end
    end

    // round-robin search starting one past the last winner
    always_comb begin
        int v_idx;
        w_gnt_found = 1'b0;
        w_gnt_ch    = '0;
        v_idx       = 0;
        for (int k = 1; k <= NCH; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NCH) begin
                v_idx = v_idx - NCH;
            end
            if (!w_gnt_found && w_elig[v_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_ch    = CHW'(v_idx);
            end
        end
    end

    // update arithmetic: DIF = WI*32 - Y (the +2^17 bias vanishes mod 2^17); only DIF[16:5] is
    // needed, which equals WI - Y[12:5] minus a borrow when Y[4:0] is nonzero
    always_comb begin
        w_dif_hi = r_s1_wi - {4'b0, r_s1_y[12:5]} - {11'b0, (r_s1_y[4:0] != 5'd0)};
        w_difsx  = {w_dif_hi[11], w_dif_hi};
        w_yut    = r_s1_y + w_difsx;
        if (w_yut > Y_MAX) begin
            w_yu = Y_MAX;
        end else if (w_yut < Y_MIN) begin
            w_yu = Y_MIN;
        end else begin
            w_yu = w_yut;
        end
    end

    // grant: capture request into stage 1, advance pointer, register ack pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1_v   <= 1'b0;
            r_s1_ch  <= '0;
            r_s1_wi  <= '0;
            r_s1_y   <= Y_MIN;
            r_rr_ptr <= CHW'(NCH - 1);
            r_ack    <= '0;
        end else if (w_gnt_found) begin
            r_s1_v   <= 1'b1;
            r_s1_ch  <= w_gnt_ch;
            r_s1_wi  <= w_wi_arr[w_gnt_ch];
            r_s1_y   <= r_y[w_gnt_ch];
            r_rr_ptr <= w_gnt_ch;
            r_ack    <= NCH'(1) << w_gnt_ch;
        end else begin
            r_s1_v   <= 1'b0;
            r_ack    <= '0;
        end
    end

    // writeback result broadcast; out_ch/out_y hold between results
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_y     <= Y_MIN;
        end else if (r_s1_v) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= r_s1_ch;
            r_out_y     <= w_yu;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    // per-channel scale factor: clear wins over a same-edge writeback
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_y[c] <= Y_MIN;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_clr[c]) begin
                    r_y[c] <= Y_MIN;
                end else if (r_s1_v && (r_s1_ch == CHW'(c))) begin
                    r_y[c] <= w_yu;
                end
            end
        end
    end

    assign o_ack       = r_ack;
    assign o_out_valid = r_out_valid;
    assign o_out_ch    = r_out_ch;
    assign o_out_y     = r_out_y;

endmodule

// File: tb/tb_sfa_sched.sv
// tb/tb_sfa_sched.sv - scoreboard testbench for sfa_sched
module tb_sfa_sched;
    localparam int NCH = 4;
    localparam int CHW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH-1:0]     req;
    logic [12*NCH-1:0]  wi;
`ifdef SFA_CLEAR_EN
    logic [NCH-1:0]     clr;
`endif
    logic [NCH-1:0]     ack;
    logic               out_valid;
    logic [CHW-1:0]     out_ch;
    logic [12:0]        out_y;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ch[$];
    int exp_y[$];
    int mon_ch;
    int mon_y;

    always #5 clk = ~clk;

    sfa_sched #(.NCH(NCH), .CHW(CHW)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req       (req),
        .i_wi        (wi),
`ifdef SFA_CLEAR_EN
        .i_clr       (clr),
`endif
        .o_ack       (ack),
        .o_out_valid (out_valid),
        .o_out_ch    (out_ch),
        .o_out_y     (out_y)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int ch, input int y);
        exp_ch.push_back(ch);
        exp_y.push_back(y);
    endtask

    // monitor: every out_valid pops one expected result
    always begin
        @(negedge clk);
        if (out_valid) begin
            if (exp_y.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got ch %0d y %0d expected none", out_ch, out_y);
            end else begin
                mon_ch = exp_ch.pop_front();
                mon_y  = exp_y.pop_front();
                check("out_ch", int'(out_ch), mon_ch);
                check("out_y", int'(out_y), mon_y);
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int ch, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!ack[ch] && cycles < 20);
        if (!ack[ch]) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack on ch %0d expected ack", ch);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_y.size() > 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", exp_y.size(), 0);
    endtask

    task automatic do_req(input int ch, input int w, input int ey);
        int cyc;
        push_exp(ch, ey);
        wi[12*ch +: 12] = 12'(w);
        req[ch] = 1'b1;
        wait_ack(ch, cyc);
        check("ack_latency", cyc, 1);
        req[ch] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int gi;
        int last_cyc;
        int cyc;
        int cnt [NCH];
        rst = 1'b1;
        req = '0;
        wi  = '0;
`ifdef SFA_CLEAR_EN
        clr = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_out_y", int'(out_y), 544);
        check("rst_out_ch", int'(out_ch), 0);
        rst = 1'b0;
        @(negedge clk);

        // basic updates
        do_req(1, 1000, 1527);
        do_req(1, 1000, 2479);
        do_req(2, 0, 544);
        do_req(2, 2047, 2574);
        do_req(2, 2047, 4540);
        do_req(2, 2047, 5120);
        drain();

        // round robin with all channels requesting
        apply_reset();
        for (int c = 0; c < NCH; c++) push_exp(c, 1527);
        for (int c = 0; c < NCH; c++) push_exp(c, 2479);
        for (int c = 0; c < NCH; c++) begin
            wi[12*c +: 12] = 12'd1000;
            cnt[c] = 0;
        end
        req = '1;
        gi = 0;
        last_cyc = 0;
        for (int t = 1; t <= 40 && gi < 8; t++) begin
            @(negedge clk);
            if (ack != '0) begin
                check("rr_onehot", $countones(ack), 1);
                for (int c = 0; c < NCH; c++) begin
                    if (ack[c]) begin
                        check("rr_order", c, gi % NCH);
                        if (gi > 0) check("rr_spacing", t - last_cyc, 1);
                        last_cyc = t;
                        gi++;
                        cnt[c]++;
                        if (cnt[c] == 2) req[c] = 1'b0;
                    end
                end
            end
        end
        check("rr_grants", gi, 8);
        req = '0;
        drain();

        // single channel held: one grant every second cycle
        apply_reset();
        push_exp(0, 1527);
        push_exp(0, 2479);
        push_exp(0, 3401);
        push_exp(0, 4294);
        wi[11:0] = 12'd1000;
        req[0] = 1'b1;
        gi = 0;
        last_cyc = 0;
        for (int t = 1; t <= 40 && gi < 4; t++) begin
            @(negedge clk);
            if (ack[0]) begin
                if (gi > 0) check("single_spacing", t - last_cyc, 2);
                last_cyc = t;
                gi++;
                if (gi == 4) req[0] = 1'b0;
            end
        end
        check("single_grants", gi, 4);
        req = '0;
        drain();

        // reset between grant and writeback discards the update
        apply_reset();
        wi[12*1 +: 12] = 12'd1000;
        req[1] = 1'b1;
        wait_ack(1, cyc);
        rst = 1'b1;
        req[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_ack", int'(ack), 0);
        check("midrst_out_y", int'(out_y), 544);
        rst = 1'b0;
        @(negedge clk);
        do_req(1, 1000, 1527);
        drain();

`ifdef SFA_CLEAR_EN
        // clear on the writeback edge: result reported, stored Y reinitialised
        apply_reset();
        do_req(3, 2047, 2574);
        push_exp(3, 4540);
        wi[12*3 +: 12] = 12'd2047;
        req[3] = 1'b1;
        wait_ack(3, cyc);
        req[3] = 1'b0;
        clr[3] = 1'b1;
        @(negedge clk);
        clr[3] = 1'b0;
        @(negedge clk);
        do_req(3, 2047, 2574);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
